// File: rtl/mem_stage_if.sv
// EX/MEM-to-memory-stage bus: pipeline slot, data-memory port, board I/O, writeback and redirect.
interface mem_stage_if #(
    parameter int DMEM_ADDR_BITS = 11
);
    logic                      in_valid;
    logic                      reg_wrt_en;
    logic                      is_load;
    logic                      is_store;
    logic                      is_special;
    logic [1:0]                mem_sel;
    logic [3:0]                dest_reg;
    logic [3:0]                sp_reg_addr;
    logic [4:0]                int_op;
    logic [31:0]               nxt_pc;
    logic [31:0]               alu_out;
    logic [31:0]               store_data;
    logic [DMEM_ADDR_BITS-1:0] dmem_addr;
    logic                      dmem_we;
    logic [31:0]               dmem_wdata;
    logic [31:0]               dmem_rdata;
    logic [3:0]                key_in;
    logic [9:0]                sw_in;
    logic [15:0]               hex_out;
    logic [9:0]                ledr_out;
    logic                      wb_wrt_en;
    logic [3:0]                wb_dest;
    logic [31:0]               wb_data;
    logic                      redirect_valid;
    logic [31:0]               redirect_pc;

    modport master (
        output in_valid, reg_wrt_en, is_load, is_store, is_special, mem_sel, dest_reg,
               sp_reg_addr, int_op, nxt_pc, alu_out, store_data, dmem_rdata, key_in, sw_in,
        input  dmem_addr, dmem_we, dmem_wdata, hex_out, ledr_out, wb_wrt_en, wb_dest,
               wb_data, redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, reg_wrt_en, is_load, is_store, is_special, mem_sel, dest_reg,
               sp_reg_addr, int_op, nxt_pc, alu_out, store_data, dmem_rdata, key_in, sw_in,
        output dmem_addr, dmem_we, dmem_wdata, hex_out, ledr_out, wb_wrt_en, wb_dest,
               wb_data, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/mem_stage_unit.sv
// Memory/writeback stage: data memory and board I/O access, special registers,
// key-press interrupts and RETI, with registered writeback and PC redirect.
module mem_stage_unit #(
    parameter int         DMEM_ADDR_BITS = 11,
    parameter logic [4:0] OP_RETI        = 5'h01,
    parameter logic [4:0] OP_RSR         = 5'h02,
    parameter logic [4:0] OP_WSR         = 5'h03
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);
    logic [15:0] r_hex;
    logic [9:0]  r_ledr;
    logic [31:0] r_pcs, r_iha, r_ira, r_idn;
    logic        r_int_pending;
    logic [3:0]  r_key_prev;
    logic        r_wb_wrt_en;
    logic [3:0]  r_wb_dest;
    logic [31:0] r_wb_data;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;

    logic        w_io, w_io_store;
    logic        w_hex_a, w_ledr_a, w_key_a, w_sw_a;
    logic [31:0] w_load_data, w_sp_rdata, w_wb_data;
    logic        w_sp_ok, w_sys, w_wsr, w_rsr, w_reti, w_press, w_accept;

    assign w_io       = bus.alu_out[31:28] == 4'hF;
    assign w_hex_a    = bus.alu_out == 32'hF000_0000;
    assign w_ledr_a   = bus.alu_out == 32'hF000_0004;
    assign w_key_a    = bus.alu_out == 32'hF000_0010;
    assign w_sw_a     = bus.alu_out == 32'hF000_0014;
    assign w_io_store = bus.in_valid & bus.is_store & w_io;

    assign bus.dmem_addr  = bus.alu_out[DMEM_ADDR_BITS+1:2];
    assign bus.dmem_we    = bus.in_valid & bus.is_store & ~w_io;
    assign bus.dmem_wdata = bus.store_data;

    always_comb begin
        w_load_data = 32'h0;
        if (!w_io)         w_load_data = bus.dmem_rdata;
        else if (w_hex_a)  w_load_data = {16'h0, r_hex};
        else if (w_ledr_a) w_load_data = {22'h0, r_ledr};
        else if (w_key_a)  w_load_data = {28'h0, ~bus.key_in};
        else if (w_sw_a)   w_load_data = {22'h0, bus.sw_in};
    end

    // Only indices 0..3 exist; anything above reads as zero and ignores writes.
    assign w_sp_ok = bus.sp_reg_addr[3:2] == 2'b00;

    always_comb begin
        w_sp_rdata = 32'h0;
        if (w_sp_ok) begin
            case (bus.sp_reg_addr[1:0])
                2'd0:    w_sp_rdata = r_pcs;
                2'd1:    w_sp_rdata = r_iha;
                2'd2:    w_sp_rdata = r_ira;
                default: w_sp_rdata = r_idn;
            endcase
        end
    end

    always_comb begin
        w_wb_data = bus.alu_out;
        case (bus.mem_sel)
            2'b01:   w_wb_data = w_load_data;
            2'b10:   w_wb_data = bus.nxt_pc;
            2'b11:   w_wb_data = w_sp_rdata;
            default: w_wb_data = bus.alu_out;
        endcase
    end

    // RSR needs no state change: mem_sel = 11 already routes the pre-update value.
    assign w_sys    = bus.in_valid & bus.is_special;
    assign w_wsr    = w_sys & (bus.int_op == OP_WSR) & w_sp_ok;
    assign w_rsr    = w_sys & (bus.int_op == OP_RSR);
    assign w_reti   = w_sys & (bus.int_op == OP_RETI);
    assign w_press  = |(r_key_prev & ~bus.key_in);
    // Excluding system instructions keeps RETI/WSR from racing an accept in the same cycle.
    assign w_accept = r_pcs[0] & r_int_pending & bus.in_valid & ~bus.is_special;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hex            <= '0;
            r_ledr           <= '0;
            r_pcs            <= '0;
            r_iha            <= '0;
            r_ira            <= '0;
            r_idn            <= '0;
            r_int_pending    <= 1'b0;
            r_key_prev       <= 4'hF;
            r_wb_wrt_en      <= 1'b0;
            r_wb_dest        <= '0;
            r_wb_data        <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_key_prev  <= bus.key_in;
            r_wb_wrt_en <= bus.in_valid & bus.reg_wrt_en;
            r_wb_dest   <= bus.dest_reg;
            r_wb_data   <= w_wb_data;

            if (w_io_store && w_hex_a)  r_hex  <= bus.store_data[15:0];
            if (w_io_store && w_ledr_a) r_ledr <= bus.store_data[9:0];

            if (w_wsr) begin
                case (bus.sp_reg_addr[1:0])
                    2'd0:    r_pcs <= bus.store_data;
                    2'd1:    r_iha <= bus.store_data;
                    2'd2:    r_ira <= bus.store_data;
                    default: r_idn <= bus.store_data;
                endcase
            end

            if (w_accept) begin
                r_ira <= bus.nxt_pc;
                r_pcs <= {30'h0, r_pcs[0], 1'b0};
            end
            if (w_reti) r_pcs[0] <= r_pcs[1];
            // A key press outranks a same-cycle WSR to IDN so the event is never lost.
            if (w_press) r_idn <= 32'h1;

            r_int_pending    <= w_press | (r_int_pending & ~w_accept);
            r_redirect_valid <= w_accept | w_reti;
            if (w_accept)    r_redirect_pc <= r_iha;
            else if (w_reti) r_redirect_pc <= r_ira;
        end
    end

    assign bus.hex_out        = r_hex;
    assign bus.ledr_out       = r_ledr;
    assign bus.wb_wrt_en      = r_wb_wrt_en;
    assign bus.wb_dest        = r_wb_dest;
    assign bus.wb_data        = r_wb_data;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;

    logic w_unused;
    assign w_unused = bus.is_load | w_rsr;
endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: a vector table for loads/stores/writeback,
// then hand sequences for special registers, interrupts, RETI and reset.
module tb_mem_stage_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if #(.DMEM_ADDR_BITS(11)) bus ();
    mem_stage_unit u_dut (.clk(clk), .rst(rst), .bus(bus));

    // Behavioural data memory: async read, write on posedge.
    logic [31:0] mem [0:2047];
    always @(posedge clk) if (bus.dmem_we) mem[bus.dmem_addr] <= bus.dmem_wdata;
    assign bus.dmem_rdata = mem[bus.dmem_addr];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v, wen, st;
        logic [1:0]  sel;
        logic [3:0]  dest;
        logic [31:0] alu, sd, npc;
        logic [9:0]  sw;
        logic        e_we;
        logic [10:0] e_addr;
        logic        e_wben;
        logic [31:0] e_wb;
        logic [15:0] e_hex;
        logic [9:0]  e_ledr;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic v, wen, st, sp, input logic [1:0] sel,
                         input logic [3:0] dest, spa, input logic [4:0] iop,
                         input logic [31:0] npc, alu, sd);
        @(negedge clk);
        bus.in_valid    = v;
        bus.reg_wrt_en  = wen;
        bus.is_store    = st;
        bus.is_special  = sp;
        bus.is_load     = v & ~sp & (sel == 2'b01);
        bus.mem_sel     = sel;
        bus.dest_reg    = dest;
        bus.sp_reg_addr = spa;
        bus.int_op      = iop;
        bus.nxt_pc      = npc;
        bus.alu_out     = alu;
        bus.store_data  = sd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [31:0] npc, alu, input logic [3:0] dest);
        issue(1, 1, 0, 0, 2'b00, dest, 4'd0, 5'd0, npc, alu, 32'h0);
    endtask
    task automatic wsr(input logic [3:0] spa, input logic [31:0] val);
        issue(1, 0, 0, 1, 2'b00, 4'd0, spa, 5'h03, 32'h0, 32'h0, val);
    endtask
    task automatic rsr(input logic [3:0] spa);
        issue(1, 1, 0, 1, 2'b11, 4'd1, spa, 5'h02, 32'h0, 32'h0, 32'h0);
    endtask
    task automatic reti();
        issue(1, 0, 0, 1, 2'b00, 4'd0, 4'd0, 5'h01, 32'h0, 32'h0, 32'h0);
    endtask
    task automatic bubble();
        issue(0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        //            v  wen st sel    dest   alu            sd             npc     sw      we addr   wben wb             hex       ledr
        tbl[0]  = '{1, 0, 1, 2'b00, 4'd0,  32'h0000_0040, 32'hDEAD_BEEF, 32'h10, 10'h0,   1, 11'd16, 0, 32'h0,         16'h0,    10'h0};
        tbl[1]  = '{1, 1, 0, 2'b01, 4'd3,  32'h0000_0040, 32'h0,         32'h14, 10'h0,   0, 11'd16, 1, 32'hDEAD_BEEF, 16'h0,    10'h0};
        tbl[2]  = '{1, 0, 1, 2'b00, 4'd0,  32'hF000_0000, 32'h0000_1234, 32'h18, 10'h0,   0, 11'd0,  0, 32'h0,         16'h1234, 10'h0};
        tbl[3]  = '{1, 0, 1, 2'b00, 4'd0,  32'hF000_0004, 32'h0000_03FF, 32'h1C, 10'h0,   0, 11'd1,  0, 32'h0,         16'h1234, 10'h3FF};
        tbl[4]  = '{1, 1, 0, 2'b01, 4'd4,  32'hF000_0014, 32'h0,         32'h20, 10'h155, 0, 11'd5,  1, 32'h155,       16'h1234, 10'h3FF};
        tbl[5]  = '{1, 1, 0, 2'b01, 4'd4,  32'hF000_0010, 32'h0,         32'h24, 10'h155, 0, 11'd4,  1, 32'h0,         16'h1234, 10'h3FF};
        tbl[6]  = '{1, 1, 0, 2'b01, 4'd6,  32'hF000_0000, 32'h0,         32'h28, 10'h0,   0, 11'd0,  1, 32'h1234,      16'h1234, 10'h3FF};
        tbl[7]  = '{1, 1, 0, 2'b01, 4'd7,  32'hF000_0004, 32'h0,         32'h2C, 10'h0,   0, 11'd1,  1, 32'h3FF,       16'h1234, 10'h3FF};
        tbl[8]  = '{1, 1, 0, 2'b01, 4'd8,  32'hF000_0020, 32'h0,         32'h30, 10'h3FF, 0, 11'd8,  1, 32'h0,         16'h1234, 10'h3FF};
        tbl[9]  = '{1, 0, 1, 2'b00, 4'd0,  32'hF000_0010, 32'hFFFF_FFFF, 32'h34, 10'h0,   0, 11'd4,  0, 32'h0,         16'h1234, 10'h3FF};
        tbl[10] = '{1, 1, 0, 2'b00, 4'd5,  32'h0000_0077, 32'h0,         32'h38, 10'h0,   0, 11'h1D, 1, 32'h77,        16'h1234, 10'h3FF};
        tbl[11] = '{1, 1, 0, 2'b10, 4'd15, 32'h0000_0000, 32'h0,         32'h108,10'h0,   0, 11'd0,  1, 32'h108,       16'h1234, 10'h3FF};
        tbl[12] = '{0, 1, 1, 2'b00, 4'd9,  32'h0000_0040, 32'h1111_1111, 32'h40, 10'h0,   0, 11'd16, 0, 32'h0,         16'h1234, 10'h3FF};
        tbl[13] = '{0, 0, 1, 2'b00, 4'd0,  32'hF000_0000, 32'h0000_FFFF, 32'h44, 10'h0,   0, 11'd0,  0, 32'h0,         16'h1234, 10'h3FF};

        rst = 1'b1;
        bus.key_in = 4'hF;
        bus.sw_in  = 10'h0;
        bubble();
        tick();
        tick();
        chk("rst wb_wrt_en", 32'(bus.wb_wrt_en), 32'h0);
        chk("rst wb_data", bus.wb_data, 32'h0);
        chk("rst hex", 32'(bus.hex_out), 32'h0);
        chk("rst ledr", 32'(bus.ledr_out), 32'h0);
        chk("rst redirect_valid", 32'(bus.redirect_valid), 32'h0);
        chk("rst redirect_pc", bus.redirect_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].v, tbl[i].wen, tbl[i].st, 1'b0, tbl[i].sel, tbl[i].dest, 4'd0, 5'd0,
                  tbl[i].npc, tbl[i].alu, tbl[i].sd);
            bus.sw_in = tbl[i].sw;
            #1;
            chk($sformatf("v%0d dmem_we", i), 32'(bus.dmem_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d dmem_addr", i), 32'(bus.dmem_addr), 32'(tbl[i].e_addr));
            tick();
            chk($sformatf("v%0d wb_wrt_en", i), 32'(bus.wb_wrt_en), 32'(tbl[i].e_wben));
            if (tbl[i].e_wben) begin
                chk($sformatf("v%0d wb_dest", i), 32'(bus.wb_dest), 32'(tbl[i].dest));
                chk($sformatf("v%0d wb_data", i), bus.wb_data, tbl[i].e_wb);
            end
            chk($sformatf("v%0d hex", i), 32'(bus.hex_out), 32'(tbl[i].e_hex));
            chk($sformatf("v%0d ledr", i), 32'(bus.ledr_out), 32'(tbl[i].e_ledr));
            chk($sformatf("v%0d redirect", i), 32'(bus.redirect_valid), 32'h0);
        end

        // Interrupt setup and accept.
        wsr(4'd1, 32'h200); tick();
        wsr(4'd0, 32'h1);   tick();
        rsr(4'd1); tick();
        chk("rsr iha", bus.wb_data, 32'h200);
        rsr(4'd5); tick();
        chk("rsr idx5 en", 32'(bus.wb_wrt_en), 32'h1);
        chk("rsr idx5", bus.wb_data, 32'h0);
        bubble(); bus.key_in = 4'hE; tick();
        chk("press no redirect", 32'(bus.redirect_valid), 32'h0);
        alu_op(32'h104, 32'h55, 4'd2); tick();
        chk("accept rv", 32'(bus.redirect_valid), 32'h1);
        chk("accept rpc", bus.redirect_pc, 32'h200);
        chk("accept wb_en", 32'(bus.wb_wrt_en), 32'h1);
        chk("accept wb_data", bus.wb_data, 32'h55);
        rsr(4'd2); tick();
        chk("rv one pulse", 32'(bus.redirect_valid), 32'h0);
        chk("ira", bus.wb_data, 32'h104);
        rsr(4'd0); tick();
        chk("pcs after accept", bus.wb_data, 32'h2);
        rsr(4'd3); tick();
        chk("idn", bus.wb_data, 32'h1);

        // RETI with a coincident key press: RETI redirect first, accept on next valid.
        bubble(); bus.key_in = 4'hF; tick();
        reti(); bus.key_in = 4'hE; tick();
        chk("reti rv", 32'(bus.redirect_valid), 32'h1);
        chk("reti rpc", bus.redirect_pc, 32'h104);
        rsr(4'd0); tick();
        chk("special no accept", 32'(bus.redirect_valid), 32'h0);
        chk("pcs after reti", bus.wb_data, 32'h3);
        alu_op(32'h300, 32'h1, 4'd1); tick();
        chk("post-reti accept rv", 32'(bus.redirect_valid), 32'h1);
        chk("post-reti accept rpc", bus.redirect_pc, 32'h200);
        rsr(4'd2); tick();
        chk("ira 300", bus.wb_data, 32'h300);

        // Press while disabled is held until PCS[0] is set.
        bubble(); bus.key_in = 4'hF; tick();
        bubble(); bus.key_in = 4'hE; tick();
        alu_op(32'h500, 32'h2, 4'd1); tick();
        chk("disabled no redirect", 32'(bus.redirect_valid), 32'h0);
        wsr(4'd0, 32'h1); tick();
        chk("wsr no redirect", 32'(bus.redirect_valid), 32'h0);
        alu_op(32'h400, 32'h3, 4'd1); tick();
        chk("held accept rv", 32'(bus.redirect_valid), 32'h1);
        chk("held accept rpc", bus.redirect_pc, 32'h200);
        rsr(4'd2); tick();
        chk("ira 400", bus.wb_data, 32'h400);

        // Reset while an accept is about to happen.
        wsr(4'd0, 32'h1); tick();
        bubble(); bus.key_in = 4'hF; tick();
        bubble(); bus.key_in = 4'hE; tick();
        chk("hex before rst", 32'(bus.hex_out), 32'h1234);
        alu_op(32'h700, 32'h9, 4'd3); bus.key_in = 4'hF; rst = 1'b1; tick();
        chk("mid rst wb_en", 32'(bus.wb_wrt_en), 32'h0);
        chk("mid rst wb_data", bus.wb_data, 32'h0);
        chk("mid rst hex", 32'(bus.hex_out), 32'h0);
        chk("mid rst ledr", 32'(bus.ledr_out), 32'h0);
        chk("mid rst rv", 32'(bus.redirect_valid), 32'h0);
        chk("mid rst rpc", bus.redirect_pc, 32'h0);
        @(negedge clk); rst = 1'b0;
        wsr(4'd0, 32'h1); tick();
        alu_op(32'h600, 32'h4, 4'd1); tick();
        chk("pending cleared", 32'(bus.redirect_valid), 32'h0);
        rsr(4'd1); tick();
        chk("iha reset", bus.wb_data, 32'h0);
        rsr(4'd3); tick();
        chk("idn reset", bus.wb_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
